seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider, the inverse operation to the adder datapath.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_full_adder.sv | 13 +
 rtl/div_trial_sub.sv | 38 +++
 rtl/seq_restoring_divider.sv | 145 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// the helper that sizes the iteration counter from the operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_full_adder.sv
// One-bit full adder, the building block of the ripple subtractor.
module div_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/div_trial_sub.sv
// Combinational WIDTH+1-bit ripple subtractor used for the trial subtraction:
// computes {0,minuend} - {0,subtrahend} as minuend + ~subtrahend + 1.
module div_trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_inv;
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] carry;
  // The carry out of the extension bit is just the complement of the borrow
  // bit; it only closes the chain.
  logic             unused_cout;

  assign a_ext    = {1'b0, minuend};
  assign b_inv    = ~{1'b0, subtrahend};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
    div_full_adder u_fa (
      .a    (a_ext[i]),
      .b    (b_inv[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign diff        = sum[WIDTH-1:0];
  assign borrow      = sum[WIDTH];
  assign unused_cout = carry[WIDTH+1];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one shift + trial subtraction per
// clock, start/done handshake, results held until the next accepted start.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import div_pkg::*;

  localparam int CNT_W = div_cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // Working registers; their contents only matter while in CALC.
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_w_q, quo_w_d;
  logic [WIDTH-1:0] rem_w_q, rem_w_d;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // {R,Q} shifted left by one as a single 2*WIDTH-bit register.
  assign rem_sh = {rem_w_q[WIDTH-2:0], quo_w_q[WIDTH-1]};
  assign quo_sh = {quo_w_q[WIDTH-2:0], 1'b0};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .minuend    (rem_sh),
    .subtrahend (dvs_q),
    .diff       (trial_diff),
    .borrow     (trial_borrow)
  );

  // One restoring step: keep the difference and set the quotient bit unless the trial borrowed.
  always_comb begin
    rem_next = trial_borrow ? rem_sh : trial_diff;
    quo_next = {quo_sh[WIDTH-1:1], ~trial_borrow};
  end

  // Next-state, counter, working-register and result-register computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    dvs_d       = dvs_q;
    quo_w_d     = quo_w_q;
    rem_w_d     = rem_w_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = CALC;
            dvs_d   = divisor;
            quo_w_d = dividend;
            rem_w_d = '0;
            cnt_d   = CNT_W'(WIDTH);
            dbz_d   = 1'b0;
          end else begin
            // Division by zero finishes straight away with saturated quotient.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
        end
      end
      CALC: begin
        quo_w_d = quo_next;
        rem_w_d = rem_next;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          quotient_d  = quo_next;
          remainder_d = rem_next;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Control and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Working datapath registers; loaded on acceptance so no reset is needed.
  always_ff @(posedge clk) begin
    dvs_q   <= dvs_d;
    quo_w_q <= quo_w_d;
    rem_w_q <= rem_w_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4) against a
// plain / and % reference model.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Reference model
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return '1;
    return a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return a;
    return a % b;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
    return (b == 0) ? 1 : W + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, wait (bounded) for done, capture results,
  // then move one cycle on so the next call starts right after done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic dbz,
                        output logic busy1);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    busy1    = busy;
    lat      = 1;
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
    step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (quotient !== '0) $display("FAIL reset_q got=%h exp=0", quotient); else n_pass++;
    n_checks++; if (remainder !== '0) $display("FAIL reset_r got=%h exp=0", remainder); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b exp=0", div_by_zero); else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] q, r; logic dbz, b1;
    run_op(4'd7, 4'd2, lat, q, r, dbz, b1);
    n_checks++; if (b1 !== 1'b1) $display("FAIL basic_busy got=%b exp=1", b1); else n_pass++;
    n_checks++; if (lat != 5) $display("FAIL basic_latency got=%0d exp=5", lat); else n_pass++;
    n_checks++; if (q !== 4'd3) $display("FAIL basic_q got=%0d exp=3", q); else n_pass++;
    n_checks++; if (r !== 4'd1) $display("FAIL basic_r got=%0d exp=1", r); else n_pass++;
    n_checks++; if (dbz !== 1'b0) $display("FAIL basic_dbz got=%b exp=0", dbz); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL basic_idle_after got busy=%b done=%b exp 0 0", busy, done); else n_pass++;
  endtask

  task automatic test_edges();
    logic [W-1:0] as [5] = '{4'd3, 4'd15, 4'd15, 4'd0, 4'd11};
    logic [W-1:0] bs [5] = '{4'd7, 4'd15, 4'd1, 4'd5, 4'd12};
    int lat; logic [W-1:0] q, r; logic dbz, b1;
    for (int i = 0; i < 5; i++) begin
      run_op(as[i], bs[i], lat, q, r, dbz, b1);
      n_checks++; if (q !== ref_q(as[i], bs[i]))
        $display("FAIL edge_q %0d/%0d got=%0d exp=%0d", as[i], bs[i], q, ref_q(as[i], bs[i])); else n_pass++;
      n_checks++; if (r !== ref_r(as[i], bs[i]))
        $display("FAIL edge_r %0d/%0d got=%0d exp=%0d", as[i], bs[i], r, ref_r(as[i], bs[i])); else n_pass++;
      n_checks++; if (lat != ref_lat(bs[i]))
        $display("FAIL edge_latency %0d/%0d got=%0d exp=%0d", as[i], bs[i], lat, ref_lat(bs[i])); else n_pass++;
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [W-1:0] q, r; logic dbz, b1;
    run_op(4'd9, 4'd0, lat, q, r, dbz, b1);
    n_checks++; if (lat != 1) $display("FAIL dz_latency got=%0d exp=1", lat); else n_pass++;
    n_checks++; if (q !== 4'hF) $display("FAIL dz_q got=%h exp=f", q); else n_pass++;
    n_checks++; if (r !== 4'd9) $display("FAIL dz_r got=%0d exp=9", r); else n_pass++;
    n_checks++; if (dbz !== 1'b1) $display("FAIL dz_flag got=%b exp=1", dbz); else n_pass++;
    step();
    n_checks++; if (div_by_zero !== 1'b1 || quotient !== 4'hF || remainder !== 4'd9)
      $display("FAIL dz_hold got dbz=%b q=%h r=%0d exp 1 f 9", div_by_zero, quotient, remainder); else n_pass++;
    run_op(4'd8, 4'd3, lat, q, r, dbz, b1);
    n_checks++; if (dbz !== 1'b0) $display("FAIL dz_clear got=%b exp=0", dbz); else n_pass++;
    n_checks++; if (q !== 4'd2 || r !== 4'd2)
      $display("FAIL dz_next got q=%0d r=%0d exp q=2 r=2", q, r); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int d0;
    int cyc;
    d0       = done_cnt;
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    step();                       // cycle 1
    start    = 1'b0;
    step();                       // cycle 2
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd3;
    step();                       // cycle 3
    start    = 1'b0;
    cyc      = 3;
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    n_checks++; if (cyc != 5) $display("FAIL busy_ign_latency got=%0d exp=5", cyc); else n_pass++;
    n_checks++; if (quotient !== 4'd3 || remainder !== 4'd1)
      $display("FAIL busy_ign_result got q=%0d r=%0d exp q=3 r=1", quotient, remainder); else n_pass++;
    repeat (6) step();
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL busy_ign_done_count got=%0d exp=1", done_cnt - d0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL busy_ign_idle got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    int lat; logic [W-1:0] q, r; logic dbz, b1;
    dividend = 4'd14;
    divisor  = 4'd5;
    start    = 1'b1;
    step();                       // cycle 1
    start    = 1'b0;
    step();                       // cycle 2
    d0    = done_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_outputs got q=%0d r=%0d dbz=%b done=%b exp all 0",
               quotient, remainder, div_by_zero, done); else n_pass++;
    repeat (6) step();
    rst_n = 1'b1;
    step();
    n_checks++; if (done_cnt != d0) $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt - d0); else n_pass++;
    run_op(4'd14, 4'd5, lat, q, r, dbz, b1);
    n_checks++; if (q !== 4'd2 || r !== 4'd4 || lat != 5)
      $display("FAIL rstmid_rerun got q=%0d r=%0d lat=%0d exp q=2 r=4 lat=5", q, r, lat); else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] q, r, a, b; logic dbz, b1;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op(a, b, lat, q, r, dbz, b1);
      n_checks++; if (q !== ref_q(a, b) || r !== ref_r(a, b) || dbz !== (b == 0) || lat != ref_lat(b))
        $display("FAIL rand_op %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d exp q=%0d r=%0d lat=%0d",
                 a, b, q, r, dbz, lat, ref_q(a, b), ref_r(a, b), ref_lat(b)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back_sweep();
    int d0;
    int lat; logic [W-1:0] q, r; logic dbz, b1;
    d0 = done_cnt;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), lat, q, r, dbz, b1);
        n_checks++; if (q !== ref_q(W'(a), W'(b)) || r !== ref_r(W'(a), W'(b)))
          $display("FAIL sweep %0d/%0d got q=%0d r=%0d exp q=%0d r=%0d",
                   a, b, q, r, ref_q(W'(a), W'(b)), ref_r(W'(a), W'(b))); else n_pass++;
        n_checks++; if (lat != ref_lat(W'(b)) || dbz !== (b == 0))
          $display("FAIL sweep_timing %0d/%0d got lat=%0d dbz=%b exp lat=%0d",
                   a, b, lat, dbz, ref_lat(W'(b))); else n_pass++;
      end
    end
    step();
    n_checks++; if (done_cnt - d0 != 256)
      $display("FAIL sweep_done_count got=%0d exp=256", done_cnt - d0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    test_back_to_back_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
